// File: rtl/arbiter_req_queue.sv
// Per-port ingress queues feeding a round-robin arbiter; pops the granted head word.
// Latency: grant cycle -> out_valid 1 cycle. No output backpressure; in_ready per port.
module arbiter_req_queue #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            in_valid,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
    output logic [NUM_PORTS-1:0]            in_ready,
    output logic [NUM_PORTS-1:0]            request,
    input  logic [NUM_PORTS-1:0]            grant,
    output logic                            out_valid,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic [$clog2(NUM_PORTS)-1:0]    out_port,
    output logic                            grant_err
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int OPW = $clog2(NUM_PORTS);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [NUM_PORTS][DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [NUM_PORTS][DEPTH];
    logic [PW-1:0]         wr_q  [NUM_PORTS];
    logic [PW-1:0]         wr_d  [NUM_PORTS];
    logic [PW-1:0]         rd_q  [NUM_PORTS];
    logic [PW-1:0]         rd_d  [NUM_PORTS];
    logic [CW-1:0]         cnt_q [NUM_PORTS];
    logic [CW-1:0]         cnt_d [NUM_PORTS];

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic [OPW-1:0]        out_port_q,  out_port_d;
    logic                  grant_err_q, grant_err_d;

    logic grant_onehot;
    logic pop_any;
    logic push_i, pop_i;

    // Status is derived from registered counts only, so a pop never frees space early
    // and a word being popped this cycle is never re-requested.
    always_comb begin
        in_ready = '0;
        request  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            in_ready[i] = (cnt_q[i] != FULL);
            request[i]  = (cnt_q[i] > {{(CW-1){1'b0}}, grant[i]});
        end
    end

    always_comb begin
        mem_d       = mem_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        cnt_d       = cnt_q;
        pop_any     = 1'b0;
        push_i      = 1'b0;
        pop_i       = 1'b0;
        out_data_d  = out_data_q;
        out_port_d  = out_port_q;
        grant_onehot = (grant != '0) && ((grant & (grant - NUM_PORTS'(1))) == '0);
        for (int i = 0; i < NUM_PORTS; i++) begin
            push_i = in_valid[i] && (cnt_q[i] != FULL);
            pop_i  = grant_onehot && grant[i] && (cnt_q[i] != '0);
            if (push_i) begin
                mem_d[i][wr_q[i]] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
                wr_d[i]           = wr_q[i] + PW'(1);
            end
            if (pop_i) begin
                rd_d[i]    = rd_q[i] + PW'(1);
                pop_any    = 1'b1;
                out_data_d = mem_q[i][rd_q[i]];
                out_port_d = OPW'(i);
            end
            cnt_d[i] = cnt_q[i] + CW'(push_i) - CW'(pop_i);
        end
        out_valid_d = pop_any;
        // Any non-idle grant that did not produce a pop is a multi-hot or empty-port grant.
        grant_err_d = (grant != '0) && !pop_any;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                wr_q[i]  <= '0;
                rd_q[i]  <= '0;
                cnt_q[i] <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    mem_q[i][j] <= '0;
                end
            end
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_port_q  <= '0;
            grant_err_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_port_q  <= out_port_d;
            grant_err_q <= grant_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_port  = out_port_q;
    assign grant_err = grant_err_q;

endmodule

// File: tb/tb_arbiter_req_queue.sv
// Directed bench for arbiter_req_queue (NUM_PORTS=4, DATA_WIDTH=8, DEPTH=4).
module tb_arbiter_req_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic [3:0]  request;
    logic [3:0]  grant;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_port;
    logic        grant_err;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    arbiter_req_queue #(.NUM_PORTS(4), .DATA_WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .request(request), .grant(grant),
        .out_valid(out_valid), .out_data(out_data), .out_port(out_port),
        .grant_err(grant_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_expect(input string tag, input logic [3:0] g,
                              input logic [7:0] d, input logic [1:0] p);
        grant = g;
        tick();
        check({tag, "_vld"}, 32'(out_valid), 32'd1);
        check({tag, "_dat"}, 32'(out_data), 32'(d));
        check({tag, "_port"}, 32'(out_port), 32'(p));
        check({tag, "_err"}, 32'(grant_err), 32'd0);
        grant = 4'b0000;
    endtask

    initial begin
        rst = 1'b1; in_valid = '0; in_data = '0; grant = '0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_port", 32'(out_port), 32'd0);
        check("rst_grant_err", 32'(grant_err), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'hF);
        check("rst_request", 32'(request), 32'h0);
        @(negedge clk); rst = 1'b0;
        tick();

        // Single port: two words on port 2
        in_valid = 4'b0100; in_data = 32'h00A1_0000; tick();
        in_data = 32'h00A2_0000; tick();
        in_valid = 4'b0000;
        check("sp_request_idle", 32'(request), 32'h4);
        grant = 4'b0100; #1;
        check("sp_request_g1", 32'(request), 32'h4);
        tick();
        check("sp_vld1", 32'(out_valid), 32'd1);
        check("sp_dat1", 32'(out_data), 32'hA1);
        check("sp_port1", 32'(out_port), 32'd2);
        check("sp_request_g2", 32'(request), 32'h0);
        tick();
        check("sp_vld2", 32'(out_valid), 32'd1);
        check("sp_dat2", 32'(out_data), 32'hA2);
        grant = 4'b0000; tick();
        check("sp_vld_idle", 32'(out_valid), 32'd0);
        check("sp_dat_hold", 32'(out_data), 32'hA2);
        check("sp_err_idle", 32'(grant_err), 32'd0);

        // Full: five pushes to port 0, fifth dropped
        in_valid = 4'b0001;
        for (int k = 1; k <= 5; k++) begin
            in_data = 32'(k);
            if (k == 5) check("full_in_ready0", 32'(in_ready), 32'hE);
            tick();
        end
        in_valid = 4'b0000;
        for (int k = 1; k <= 4; k++) pop_expect("full_pop", 4'b0001, 8'(k), 2'd0);
        tick();
        check("full_drained_vld", 32'(out_valid), 32'd0);
        check("full_drained_req", 32'(request), 32'h0);

        // Port 1: push+pop at count 4 (push refused), then at count 3 (both happen)
        in_valid = 4'b0010;
        for (int k = 1; k <= 4; k++) begin
            in_data = {16'h0, 8'(8'h10 + k), 8'h00};
            tick();
        end
        in_data = 32'h0000_1500; grant = 4'b0010;
        check("pp4_in_ready1", 32'(in_ready), 32'hD);
        tick();
        check("pp4_dat", 32'(out_data), 32'h11);
        check("pp4_in_ready_after", 32'(in_ready), 32'hF);
        in_data = 32'h0000_1600;
        tick();
        check("pp3_dat", 32'(out_data), 32'h12);
        check("pp3_in_ready_after", 32'(in_ready), 32'hF);
        in_valid = 4'b0000; grant = 4'b0000;
        pop_expect("pp_drain1", 4'b0010, 8'h13, 2'd1);
        pop_expect("pp_drain2", 4'b0010, 8'h14, 2'd1);
        pop_expect("pp_drain3", 4'b0010, 8'h16, 2'd1);
        tick();
        check("pp_empty_req", 32'(request), 32'h0);

        // Protocol errors
        in_valid = 4'b0011; in_data = 32'h0000_6655; tick();
        in_valid = 4'b0000;
        grant = 4'b0011; tick();
        check("err_multi", 32'(grant_err), 32'd1);
        check("err_multi_vld", 32'(out_valid), 32'd0);
        grant = 4'b0000; tick();
        check("err_clear", 32'(grant_err), 32'd0);
        check("err_counts_kept", 32'(request), 32'h3);
        grant = 4'b1000; tick();
        check("err_empty", 32'(grant_err), 32'd1);
        check("err_empty_vld", 32'(out_valid), 32'd0);
        grant = 4'b0000;
        pop_expect("err_drain0", 4'b0001, 8'h55, 2'd0);
        pop_expect("err_drain1", 4'b0010, 8'h66, 2'd1);

        // Round-robin drain: 3 words on every port, grants 3,2,1,0 repeating
        in_valid = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            in_data = {8'(8'h30 + k), 8'(8'h20 + k), 8'(8'h10 + k), 8'(8'h00 + k)};
            tick();
        end
        in_valid = 4'b0000;
        for (int r = 0; r < 3; r++) begin
            for (int p = 3; p >= 0; p--) begin
                pop_expect("rr", 4'(1 << p), 8'((p << 4) + r), 2'(p));
                if (out_valid) pulses++;
            end
        end
        check("rr_pulses", 32'(pulses), 32'd12);
        tick();
        check("rr_req_empty", 32'(request), 32'h0);

        // Async reset mid-traffic drops queued words
        in_valid = 4'b0101; in_data = 32'h00C3_00C1; tick();
        tick();
        in_valid = 4'b0000; grant = 4'b0001;
        @(posedge clk); #3;
        rst = 1'b1; #1;
        check("mid_rst_request", 32'(request), 32'h0);
        check("mid_rst_in_ready", 32'(in_ready), 32'hF);
        check("mid_rst_vld", 32'(out_valid), 32'd0);
        grant = 4'b0000;
        @(negedge clk); rst = 1'b0;
        grant = 4'b0001; tick();
        check("post_rst_vld0", 32'(out_valid), 32'd0);
        check("post_rst_err0", 32'(grant_err), 32'd1);
        grant = 4'b0100; tick();
        check("post_rst_vld2", 32'(out_valid), 32'd0);
        check("post_rst_dat", 32'(out_data), 32'h0);
        grant = 4'b0000; tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
